// File: rtl/sync_frame_detector_if.sv
// sync_frame_detector_if
//   Bus bundle between the bus sampler (master) and the sync frame detector
//   (slave).
//   master drives : dbus, valid, pattern (and mask when PATTERN_MASK_EN)
//   slave drives  : wren, dout, sof, eof, locked, frame_cnt
//   Macro: PATTERN_MASK_EN adds the per-bit sync compare mask.
interface sync_frame_detector_if #(
    parameter int WIDTH    = 16,
    parameter int SYNC_LEN = 2,
    parameter int CNT_W    = 8
);
    logic [WIDTH-1:0]          dbus;
    logic                      valid;
    logic [WIDTH*SYNC_LEN-1:0] pattern;
`ifdef PATTERN_MASK_EN
    logic [WIDTH*SYNC_LEN-1:0] mask;
`endif
    logic                      wren;
    logic [WIDTH-1:0]          dout;
    logic                      sof;
    logic                      eof;
    logic                      locked;
    logic [CNT_W-1:0]          frame_cnt;

`ifdef PATTERN_MASK_EN
    modport master (output dbus, valid, pattern, mask,
                    input  wren, dout, sof, eof, locked, frame_cnt);
    modport slave  (input  dbus, valid, pattern, mask,
                    output wren, dout, sof, eof, locked, frame_cnt);
`else
    modport master (output dbus, valid, pattern,
                    input  wren, dout, sof, eof, locked, frame_cnt);
    modport slave  (input  dbus, valid, pattern,
                    output wren, dout, sof, eof, locked, frame_cnt);
`endif
endinterface

// File: rtl/sync_frame_detector.sv
// sync_frame_detector
//   Hunts a SYNC_LEN-word sync pattern on dbus, then passes PAYLOAD_LEN
//   payload words to the capture memory with a one-cycle registered delay.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous reset, active low
//     bus    - sync_frame_detector_if.slave
//              in : dbus, valid, pattern (word 0 in the low WIDTH bits),
//                   mask (PATTERN_MASK_EN only, 1 = compare this bit)
//              out: wren, dout, sof, eof, locked, frame_cnt (all registered)
//   Macro: PATTERN_MASK_EN enables masked sync compares; undefined means
//   exact equality on every sync word.
module sync_frame_detector #(
    parameter int WIDTH       = 16,
    parameter int SYNC_LEN    = 2,
    parameter int PAYLOAD_LEN = 8,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sync_frame_detector_if.slave  bus
);
    localparam int IDX_W = $clog2(SYNC_LEN + 1);
    localparam int PC_W  = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;

    typedef enum logic [1:0] {HUNT, MATCH, PAYLOAD} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [PC_W-1:0]  pcnt;
    logic             wren_q, sof_q, eof_q, locked_q;
    logic [WIDTH-1:0] dout_q;
    logic [CNT_W-1:0] frame_cnt_q;

    // Sync compares: the word currently expected (idx) and word 0, which
    // is needed for the restart rule on a mismatch.
    logic [WIDTH-1:0] pat_idx, pat0, msk_idx, msk0;
    logic             hit_idx, hit0;

    always_comb begin
        pat_idx = bus.pattern[int'(idx) * WIDTH +: WIDTH];
        pat0    = bus.pattern[WIDTH-1:0];
`ifdef PATTERN_MASK_EN
        msk_idx = bus.mask[int'(idx) * WIDTH +: WIDTH];
        msk0    = bus.mask[WIDTH-1:0];
`else
        msk_idx = '1;
        msk0    = '1;
`endif
        hit_idx = ((bus.dbus ^ pat_idx) & msk_idx) == '0;
        hit0    = ((bus.dbus ^ pat0) & msk0) == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            idx         <= '0;
            pcnt        <= '0;
            wren_q      <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            locked_q    <= 1'b0;
            dout_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            // Strobes are single-cycle; they are only raised by a valid
            // payload word below.
            wren_q <= 1'b0;
            sof_q  <= 1'b0;
            eof_q  <= 1'b0;
            if (bus.valid) begin
                case (state)
                    HUNT: begin
                        if (hit0) begin
                            if (SYNC_LEN == 1) begin
                                state    <= PAYLOAD;
                                locked_q <= 1'b1;
                                idx      <= '0;
                            end else begin
                                state <= MATCH;
                                idx   <= IDX_W'(1);
                            end
                        end
                    end
                    MATCH: begin
                        if (hit_idx) begin
                            if (idx == IDX_W'(SYNC_LEN - 1)) begin
                                state    <= PAYLOAD;
                                locked_q <= 1'b1;
                                idx      <= '0;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end else if (hit0) begin
                            // Mismatch that could itself start a new sync run.
                            idx <= IDX_W'(1);
                        end else begin
                            state <= HUNT;
                            idx   <= '0;
                        end
                    end
                    PAYLOAD: begin
                        // No sync compare here: every word is payload,
                        // including one that looks like sync word 0.
                        dout_q <= bus.dbus;
                        wren_q <= 1'b1;
                        sof_q  <= (pcnt == '0);
                        if (pcnt == PC_W'(PAYLOAD_LEN - 1)) begin
                            eof_q       <= 1'b1;
                            state       <= HUNT;
                            locked_q    <= 1'b0;
                            pcnt        <= '0;
                            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                        end else begin
                            pcnt <= pcnt + PC_W'(1);
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        idx      <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.wren      = wren_q;
    assign bus.dout      = dout_q;
    assign bus.sof       = sof_q;
    assign bus.eof       = eof_q;
    assign bus.locked    = locked_q;
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_sync_frame_detector.sv
// tb_sync_frame_detector
//   Directed bench: WIDTH=16, SYNC_LEN=2, PAYLOAD_LEN=4, sync = AAAA then 5555.
//   Honours PATTERN_MASK_EN for the masked-compare cases.
module tb_sync_frame_detector;
    localparam int WIDTH = 16, SYNC_LEN = 2, PAYLOAD_LEN = 4, CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sync_frame_detector_if #(.WIDTH(WIDTH), .SYNC_LEN(SYNC_LEN), .CNT_W(CNT_W)) bus ();

    sync_frame_detector #(.WIDTH(WIDTH), .SYNC_LEN(SYNC_LEN),
                          .PAYLOAD_LEN(PAYLOAD_LEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {wren, sof, eof, locked}
    task automatic chk_fl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, bus.wren, bus.sof, bus.eof, bus.locked}, {28'd0, exp});
    endtask

    // Present one word at the falling edge; return just after the rising
    // edge that registers it.
    task automatic step(input logic [15:0] d, input logic v);
        @(negedge clk);
        bus.dbus  = d;
        bus.valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [15:0] base);
        step(16'hAAAA, 1'b1);
        step(16'h5555, 1'b1);
        for (int i = 0; i < 4; i++) step(base + 16'(i), 1'b1);
    endtask

    initial begin
        bus.dbus    = 16'($urandom);
        bus.valid   = 1'b0;
        bus.pattern = {16'h5555, 16'hAAAA};
`ifdef PATTERN_MASK_EN
        bus.mask    = '1;
`endif
        // 1: reset
        repeat (2) begin
            @(posedge clk);
            bus.dbus = 16'($urandom);
        end
        #1;
        chk_fl("rst_flags", 4'b0000);
        chk("rst_dout", 32'(bus.dout), 32'h0);
        chk("rst_fcnt", 32'(bus.frame_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(16'h1234, 1'b1);
        chk_fl("post_rst_1", 4'b0000);
        step(16'h0000, 1'b1);
        chk_fl("post_rst_2", 4'b0000);

        // 2: basic frame
        step(16'hAAAA, 1'b1); chk_fl("t2_sync0", 4'b0000);
        step(16'h5555, 1'b1); chk_fl("t2_sync1", 4'b0001);
        step(16'h1111, 1'b1); chk_fl("t2_p0", 4'b1101);
        chk("t2_d0", 32'(bus.dout), 32'h1111);
        step(16'h2222, 1'b1); chk_fl("t2_p1", 4'b1001);
        chk("t2_d1", 32'(bus.dout), 32'h2222);
        step(16'h3333, 1'b1); chk_fl("t2_p2", 4'b1001);
        chk("t2_d2", 32'(bus.dout), 32'h3333);
        step(16'h4444, 1'b1); chk_fl("t2_p3", 4'b1010);
        chk("t2_d3", 32'(bus.dout), 32'h4444);
        chk("t2_fcnt", 32'(bus.frame_cnt), 32'd1);
        step(16'h0000, 1'b0); chk_fl("t2_idle", 4'b0000);

        // 3: restart rule, then a broken sync
        step(16'hAAAA, 1'b1);
        step(16'hAAAA, 1'b1); chk_fl("t3_restart", 4'b0000);
        step(16'h5555, 1'b1); chk_fl("t3_lock", 4'b0001);
        step(16'h0001, 1'b1); chk_fl("t3_p0", 4'b1101);
        step(16'h0002, 1'b1);
        step(16'h0003, 1'b1);
        step(16'h0004, 1'b1); chk_fl("t3_p3", 4'b1010);
        chk("t3_d3", 32'(bus.dout), 32'h0004);
        chk("t3_fcnt", 32'(bus.frame_cnt), 32'd2);
        step(16'hAAAA, 1'b1); chk_fl("t3_bad0", 4'b0000);
        step(16'h0040, 1'b1); chk_fl("t3_bad1", 4'b0000);
        step(16'h5555, 1'b1); chk_fl("t3_bad2", 4'b0000);
        step(16'h0133, 1'b1); chk_fl("t3_bad3", 4'b0000);

        // 4: valid gap inside payload; last payload word looks like sync 0
        frame_start: begin
            step(16'hAAAA, 1'b1);
            step(16'h5555, 1'b1);
        end
        step(16'h0A01, 1'b1); chk_fl("t4_p0", 4'b1101);
        step(16'h0A02, 1'b1); chk_fl("t4_p1", 4'b1001);
        for (int i = 0; i < 3; i++) begin
            step(16'hAAAA, 1'b0);
            chk_fl("t4_gap", 4'b0001);
        end
        step(16'h0A03, 1'b1); chk_fl("t4_p2", 4'b1001);
        chk("t4_d2", 32'(bus.dout), 32'h0A03);
        step(16'hAAAA, 1'b1); chk_fl("t4_p3", 4'b1010);
        chk("t4_d3", 32'(bus.dout), 32'hAAAA);
        chk("t4_fcnt", 32'(bus.frame_cnt), 32'd3);
        // AAAA above was payload, so 5555 now is just noise in HUNT
        step(16'h5555, 1'b1); chk_fl("t4_nolock", 4'b0000);
        step(16'h0001, 1'b1); chk_fl("t4_nowr", 4'b0000);

        // 5: reset mid-frame
        step(16'hAAAA, 1'b1);
        step(16'h5555, 1'b1);
        step(16'h0B01, 1'b1);
        step(16'h0B02, 1'b1); chk_fl("t5_p1", 4'b1001);
        rst_n = 1'b0;
        #1;
        chk_fl("t5_rst_flags", 4'b0000);
        chk("t5_rst_dout", 32'(bus.dout), 32'h0);
        chk("t5_rst_fcnt", 32'(bus.frame_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(16'hAAAA, 1'b1);
        step(16'h5555, 1'b1);
        step(16'h0C01, 1'b1); chk_fl("t5_p0", 4'b1101);
        step(16'h0C02, 1'b1);
        step(16'h0C03, 1'b1);
        step(16'h0C04, 1'b1); chk_fl("t5_p3", 4'b1010);
        chk("t5_fcnt", 32'(bus.frame_cnt), 32'd1);

        // Frame counter wrap
        for (int f = 0; f < 254; f++) frame(16'h1000);
        chk("wrap_255", 32'(bus.frame_cnt), 32'd255);
        frame(16'h2000);
        chk("wrap_0", 32'(bus.frame_cnt), 32'd0);
        chk_fl("wrap_eof", 4'b1010);

        // 6: masked compares
`ifdef PATTERN_MASK_EN
        bus.mask = {16'hFFFF, 16'hFF00};
        step(16'hAA20, 1'b1);
        step(16'h5555, 1'b1); chk_fl("t6_mlock0", 4'b0001);
        step(16'h0D01, 1'b1); chk_fl("t6_p0", 4'b1101);
        step(16'h0D02, 1'b1);
        step(16'h0D03, 1'b1);
        step(16'h0D04, 1'b1); chk_fl("t6_p3", 4'b1010);
        bus.mask = {16'h00FF, 16'hFF00};
        step(16'hAAAA, 1'b1);
        step(16'h2255, 1'b1); chk_fl("t6_mlock1", 4'b0001);
`else
        step(16'hAA20, 1'b1);
        step(16'h5555, 1'b1); chk_fl("t6_nomask", 4'b0000);
        step(16'h0D01, 1'b1); chk_fl("t6_nowr", 4'b0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
